// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the IF/MEM unified-RAM port arbiter.
package mem_port_arbiter_pkg;

  localparam int DEF_AW = 32;
  localparam int DEF_DW = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    RESP  = 2'd2
  } arb_state_e;

  typedef enum logic {
    OWN_IF  = 1'b0,
    OWN_MEM = 1'b1
  } arb_owner_e;

  // MEM wins whenever it asks, unless IF is also waiting and MEM has used up its streak.
  function automatic arb_owner_e pick_owner(input logic if_req,
                                            input logic mem_req,
                                            input logic at_limit);
    if (mem_req && !(if_req && at_limit)) return OWN_MEM;
    return OWN_IF;
  endfunction

endpackage

// File: rtl/mem_port_arbiter_streak_cnt.sv
// Saturating count of back-to-back MEM grants made while IF was left waiting.
module arb_streak_cnt
  import mem_port_arbiter_pkg::*;
#(
  parameter int unsigned LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam logic [3:0] LIMIT_V = 4'(LIMIT);

  logic [3:0] cnt_q;
  logic [3:0] cnt_d;

  // Clear wins over increment; the count never climbs past the limit.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = 4'd0;
    end else if (inc && (cnt_q < LIMIT_V)) begin
      cnt_d = cnt_q + 4'd1;
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= 4'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit = (cnt_q == LIMIT_V);

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single-port unified RAM between instruction fetch and load/store.
module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int AW     = DEF_AW,
  parameter int DW     = DEF_DW,
  parameter int STREAK = 4
) (
  input  logic          clk,
  input  logic          rst,

  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic          if_ack,
  output logic [DW-1:0] if_rdata,
  output logic          if_stall,

  input  logic          mem_req,
  input  logic          mem_we,
  input  logic [3:0]    mem_be,
  input  logic [AW-1:0] mem_addr,
  input  logic [DW-1:0] mem_wdata,
  output logic          mem_ack,
  output logic [DW-1:0] mem_rdata,
  output logic          mem_stall,

  output logic          ram_req,
  output logic          ram_we,
  output logic [3:0]    ram_be,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_wdata,
  input  logic          ram_ack,
  input  logic [DW-1:0] ram_rdata
);

  arb_state_e    state_q,     state_d;
  arb_owner_e    owner_q,     owner_d;
  logic          ram_we_q,    ram_we_d;
  logic [3:0]    ram_be_q,    ram_be_d;
  logic [AW-1:0] ram_addr_q,  ram_addr_d;
  logic [DW-1:0] ram_wdata_q, ram_wdata_d;
  logic [DW-1:0] if_rdata_q,  if_rdata_d;
  logic [DW-1:0] mem_rdata_q, mem_rdata_d;

  arb_owner_e    winner;
  logic          streak_inc;
  logic          streak_clr;
  logic          streak_at_limit;

  arb_streak_cnt #(
    .LIMIT (STREAK)
  ) u_streak (
    .clk      (clk),
    .rst      (rst),
    .inc      (streak_inc),
    .clr      (streak_clr),
    .at_limit (streak_at_limit)
  );

  // Next-state logic: grant and latch in IDLE, wait for the RAM in ISSUE, ack in RESP.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    ram_we_d    = ram_we_q;
    ram_be_d    = ram_be_q;
    ram_addr_d  = ram_addr_q;
    ram_wdata_d = ram_wdata_q;
    if_rdata_d  = if_rdata_q;
    mem_rdata_d = mem_rdata_q;
    winner      = OWN_IF;
    streak_inc  = 1'b0;
    streak_clr  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (if_req || mem_req) begin
          winner  = pick_owner(if_req, mem_req, streak_at_limit);
          owner_d = winner;
          if (winner == OWN_MEM) begin
            ram_we_d    = mem_we;
            ram_be_d    = mem_be;
            ram_addr_d  = mem_addr;
            ram_wdata_d = mem_wdata;
            streak_inc  = if_req;
          end else begin
            ram_we_d    = 1'b0;
            ram_be_d    = 4'd0;
            ram_addr_d  = if_addr;
            ram_wdata_d = '0;
            streak_clr  = 1'b1;
          end
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (ram_ack) begin
          if (owner_q == OWN_IF) begin
            if_rdata_d = ram_rdata;
          end else if (!ram_we_q) begin
            mem_rdata_d = ram_rdata;
          end
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latched request and returned-data registers; reset abandons any transaction.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_IF;
      ram_we_q    <= 1'b0;
      ram_be_q    <= 4'd0;
      ram_addr_q  <= '0;
      ram_wdata_q <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      ram_we_q    <= ram_we_d;
      ram_be_q    <= ram_be_d;
      ram_addr_q  <= ram_addr_d;
      ram_wdata_q <= ram_wdata_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

  assign ram_req   = (state_q == ISSUE);
  assign ram_we    = ram_we_q;
  assign ram_be    = ram_be_q;
  assign ram_addr  = ram_addr_q;
  assign ram_wdata = ram_wdata_q;

  assign if_ack    = (state_q == RESP) && (owner_q == OWN_IF);
  assign mem_ack   = (state_q == RESP) && (owner_q == OWN_MEM);
  assign if_rdata  = if_rdata_q;
  assign mem_rdata = mem_rdata_q;
  assign if_stall  = if_req  & ~if_ack;
  assign mem_stall = mem_req & ~mem_ack;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter with a RAM model and an ack scoreboard.
module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        if_stall;
  logic        mem_req;
  logic        mem_we;
  logic [3:0]  mem_be;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_stall;
  logic        ram_req;
  logic        ram_we;
  logic [3:0]  ram_be;
  logic [31:0] ram_addr;
  logic [31:0] ram_wdata;
  logic        ram_ack;
  logic [31:0] ram_rdata;

  int          n_vec;
  int          n_err;

  typedef struct {
    logic        owner;
    logic [31:0] data;
  } exp_t;
  exp_t        sb_q[$];

  int          ram_wait;
  int          wait_cnt;
  logic        stray_ack;
  logic        rd_override_en;
  logic [31:0] rd_override;
  logic [31:0] last_if_rdata;
  logic [31:0] last_mem_rdata;

  mem_port_arbiter #(
    .AW     (32),
    .DW     (32),
    .STREAK (4)
  ) u_dut (
    .clk       (clk),
    .rst       (rst),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_ack    (if_ack),
    .if_rdata  (if_rdata),
    .if_stall  (if_stall),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .mem_stall (mem_stall),
    .ram_req   (ram_req),
    .ram_we    (ram_we),
    .ram_be    (ram_be),
    .ram_addr  (ram_addr),
    .ram_wdata (ram_wdata),
    .ram_ack   (ram_ack),
    .ram_rdata (ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Read data the RAM model returns for a given address.
  function automatic logic [31:0] model_rd(input logic [31:0] a);
    return {a[15:0], 16'h0000} ^ 32'h1357_9BDF ^ a;
  endfunction

  // RAM model: acks after ram_wait cycles of ram_req; stray_ack injects a spurious ack.
  assign ram_ack   = (ram_req && (wait_cnt == ram_wait)) || stray_ack;
  assign ram_rdata = rd_override_en ? rd_override : model_rd(ram_addr);

  // Wait-cycle counter for the RAM model.
  always @(posedge clk) begin
    if (rst || !ram_req || ram_ack) wait_cnt <= 0;
    else                            wait_cnt <= wait_cnt + 1;
  end

  // Scoreboard: every ack pops the next expected owner and read data.
  always @(negedge clk) begin
    exp_t e;
    if (!rst && (if_ack || mem_ack)) begin
      n_vec++;
      if (if_ack && mem_ack) begin
        n_err++;
        $display("[TB] FAIL sb_both_acks got if_ack=1 mem_ack=1 want one-hot");
      end else if (sb_q.size() == 0) begin
        n_err++;
        $display("[TB] FAIL sb_unexpected_ack got if_ack=%0b mem_ack=%0b want no ack", if_ack, mem_ack);
      end else begin
        e = sb_q.pop_front();
        if (e.owner !== mem_ack) begin
          n_err++;
          $display("[TB] FAIL sb_owner got mem_ack=%0b want %0b", mem_ack, e.owner);
        end else if (mem_ack && (mem_rdata !== e.data)) begin
          n_err++;
          $display("[TB] FAIL sb_mem_rdata got %h want %h", mem_rdata, e.data);
        end else if (if_ack && (if_rdata !== e.data)) begin
          n_err++;
          $display("[TB] FAIL sb_if_rdata got %h want %h", if_rdata, e.data);
        end
      end
    end
  end

  // Holds reset for two cycles with all requests idle and clears bench-side history.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; if_req = 1'b0; mem_req = 1'b0; mem_we = 1'b0; stray_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    sb_q.delete();
    last_if_rdata  = '0;
    last_mem_rdata = '0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1; if_req = 1'b1; mem_req = 1'b0;
    repeat (2) @(negedge clk);
    n_vec++;
    if ({ram_req, ram_we, if_ack, mem_ack} !== 4'b0000) begin
      n_err++;
      $display("[TB] FAIL reset_ctrl got %b want 0000", {ram_req, ram_we, if_ack, mem_ack});
    end
    n_vec++;
    if ({ram_be, ram_addr, ram_wdata, if_rdata, mem_rdata} !== '0) begin
      n_err++;
      $display("[TB] FAIL reset_regs got be=%h addr=%h wd=%h ird=%h mrd=%h want 0",
               ram_be, ram_addr, ram_wdata, if_rdata, mem_rdata);
    end
    n_vec++;
    if ({if_stall, mem_stall} !== 2'b10) begin
      n_err++;
      $display("[TB] FAIL reset_stall_if got %b want 10", {if_stall, mem_stall});
    end
    if_req = 1'b0; mem_req = 1'b1;
    #1;
    n_vec++;
    if ({if_stall, mem_stall} !== 2'b01) begin
      n_err++;
      $display("[TB] FAIL reset_stall_mem got %b want 01", {if_stall, mem_stall});
    end
    mem_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_if_fetch();
    ram_wait = 0; rd_override_en = 1'b1; rd_override = 32'h2402_000A;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_0040;
    sb_q.push_back('{OWN_IF, 32'h2402_000A});
    last_if_rdata = 32'h2402_000A;
    #1;
    n_vec++;
    if ({ram_req, if_stall} !== 2'b01) begin
      n_err++;
      $display("[TB] FAIL if_cycle0 got ram_req=%0b if_stall=%0b want 0 1", ram_req, if_stall);
    end
    @(negedge clk);
    n_vec++;
    if ({ram_req, ram_we, ram_addr} !== {1'b1, 1'b0, 32'h0000_0040}) begin
      n_err++;
      $display("[TB] FAIL if_cycle1 got req=%0b we=%0b addr=%h want 1 0 00000040", ram_req, ram_we, ram_addr);
    end
    @(negedge clk);
    n_vec++;
    if ({if_ack, if_stall, if_rdata} !== {1'b1, 1'b0, 32'h2402_000A}) begin
      n_err++;
      $display("[TB] FAIL if_cycle2 got ack=%0b stall=%0b rdata=%h want 1 0 2402000a", if_ack, if_stall, if_rdata);
    end
    if_req = 1'b0;
    @(negedge clk);
    n_vec++;
    if ({if_ack, ram_req, if_rdata} !== {1'b0, 1'b0, 32'h2402_000A}) begin
      n_err++;
      $display("[TB] FAIL if_cycle3 got ack=%0b req=%0b rdata=%h want 0 0 2402000a", if_ack, ram_req, if_rdata);
    end
    rd_override_en = 1'b0;
  endtask

  task automatic test_mem_load();
    int lat;
    ram_wait = 2;
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b0; mem_be = 4'hF; mem_addr = 32'h0000_0200; mem_wdata = 32'h0;
    last_mem_rdata = model_rd(32'h0000_0200);
    sb_q.push_back('{OWN_MEM, last_mem_rdata});
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (mem_ack) begin lat = c; break; end
    end
    mem_req = 1'b0;
    n_vec++;
    if (lat != 4) begin
      n_err++;
      $display("[TB] FAIL mem_load_latency got %0d want 4", lat);
    end
  endtask

  task automatic test_mem_store();
    int lat;
    ram_wait = 3;
    @(negedge clk);
    mem_req = 1'b1; mem_we = 1'b1; mem_be = 4'b0011; mem_addr = 32'h0000_0100; mem_wdata = 32'hDEAD_BEEF;
    sb_q.push_back('{OWN_MEM, last_mem_rdata});
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clk);
      if (c == 2) begin
        mem_addr = 32'h0000_0999; mem_wdata = 32'h1111_2222; mem_we = 1'b0;
      end
      if (c == 1 || c == 4) begin
        n_vec++;
        if ({ram_req, ram_we, ram_be, ram_addr, ram_wdata} !==
            {1'b1, 1'b1, 4'b0011, 32'h0000_0100, 32'hDEAD_BEEF}) begin
          n_err++;
          $display("[TB] FAIL store_fields_c%0d got req=%0b we=%0b be=%b addr=%h wd=%h want 1 1 0011 00000100 deadbeef",
                   c, ram_req, ram_we, ram_be, ram_addr, ram_wdata);
        end
      end
      if (mem_ack) begin lat = c; break; end
    end
    mem_req = 1'b0;
    n_vec++;
    if (lat != 5) begin
      n_err++;
      $display("[TB] FAIL store_latency got %0d want 5", lat);
    end
    n_vec++;
    if (mem_rdata !== last_mem_rdata) begin
      n_err++;
      $display("[TB] FAIL store_rdata_held got %h want %h", mem_rdata, last_mem_rdata);
    end
  endtask

  task automatic test_streak();
    logic [4:0] seq;
    int         grants;
    int         n_mem;
    do_reset();
    ram_wait = 1;
    seq = '0; grants = 0; n_mem = 0;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_0080;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_0300;
    for (int i = 0; i < 4; i++) sb_q.push_back('{OWN_MEM, model_rd(32'h0000_0300)});
    sb_q.push_back('{OWN_IF, model_rd(32'h0000_0080)});
    last_mem_rdata = model_rd(32'h0000_0300);
    last_if_rdata  = model_rd(32'h0000_0080);
    for (int c = 1; c <= 100; c++) begin
      @(negedge clk);
      if (mem_ack || if_ack) begin
        seq = {seq[3:0], mem_ack};
        grants++;
      end
      if (mem_ack) begin
        n_mem++;
        n_vec++;
        if (u_dut.u_streak.cnt_q !== 4'(n_mem)) begin
          n_err++;
          $display("[TB] FAIL streak_count got %0d want %0d", u_dut.u_streak.cnt_q, n_mem);
        end
      end
      if (if_ack) begin
        n_vec++;
        if (u_dut.u_streak.cnt_q !== 4'd0) begin
          n_err++;
          $display("[TB] FAIL streak_clear got %0d want 0", u_dut.u_streak.cnt_q);
        end
        if_req = 1'b0; mem_req = 1'b0;
        break;
      end
      if (grants >= 6) break;
    end
    if_req = 1'b0; mem_req = 1'b0;
    n_vec++;
    if ((grants != 5) || (seq !== 5'b11110)) begin
      n_err++;
      $display("[TB] FAIL streak_order got grants=%0d seq=%b want 5 11110", grants, seq);
    end
  endtask

  task automatic test_simultaneous();
    int  mem_lat;
    int  if_lat;
    bit  stall_ok;
    do_reset();
    ram_wait = 0;
    mem_lat = -1; if_lat = -1; stall_ok = 1'b1;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_0044;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_0204;
    sb_q.push_back('{OWN_MEM, model_rd(32'h0000_0204)});
    sb_q.push_back('{OWN_IF,  model_rd(32'h0000_0044)});
    last_mem_rdata = model_rd(32'h0000_0204);
    last_if_rdata  = model_rd(32'h0000_0044);
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      if (mem_ack) begin mem_lat = c; mem_req = 1'b0; end
      if (if_ack) begin if_lat = c; break; end
      if (!if_stall) stall_ok = 1'b0;
    end
    if_req = 1'b0; mem_req = 1'b0;
    n_vec++;
    if ((mem_lat != 2) || (if_lat != 5)) begin
      n_err++;
      $display("[TB] FAIL simul_order got mem_ack@%0d if_ack@%0d want 2 5", mem_lat, if_lat);
    end
    n_vec++;
    if (!stall_ok) begin
      n_err++;
      $display("[TB] FAIL simul_if_stall got stall dropped before ack want held high");
    end
  endtask

  task automatic test_stray_ack();
    @(negedge clk);
    stray_ack = 1'b1;
    for (int c = 1; c <= 2; c++) begin
      @(negedge clk);
      n_vec++;
      if ({if_ack, mem_ack, ram_req} !== 3'b000 || u_dut.state_q !== IDLE ||
          if_rdata !== last_if_rdata || mem_rdata !== last_mem_rdata) begin
        n_err++;
        $display("[TB] FAIL stray_ack_c%0d got acks=%b req=%0b state=%0d ird=%h mrd=%h want 00 0 0 %h %h",
                 c, {if_ack, mem_ack}, ram_req, u_dut.state_q, if_rdata, mem_rdata, last_if_rdata, last_mem_rdata);
      end
    end
    stray_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    bit quiet;
    ram_wait = 5;
    @(negedge clk);
    if_req = 1'b1; if_addr = 32'h0000_0048;
    mem_req = 1'b1; mem_we = 1'b0; mem_addr = 32'h0000_0400;
    repeat (2) @(negedge clk);
    n_vec++;
    if ((u_dut.state_q !== ISSUE) || (ram_req !== 1'b1)) begin
      n_err++;
      $display("[TB] FAIL midrst_pre got state=%0d ram_req=%0b want 1 1", u_dut.state_q, ram_req);
    end
    rst = 1'b1; if_req = 1'b0; mem_req = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if ((u_dut.state_q !== IDLE) || ({ram_req, if_ack, mem_ack} !== 3'b000) ||
        (if_rdata !== '0) || (mem_rdata !== '0) || (u_dut.u_streak.cnt_q !== 4'd0)) begin
      n_err++;
      $display("[TB] FAIL midrst_post got state=%0d req/acks=%b ird=%h mrd=%h streak=%0d want 0 000 0 0 0",
               u_dut.state_q, {ram_req, if_ack, mem_ack}, if_rdata, mem_rdata, u_dut.u_streak.cnt_q);
    end
    quiet = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (if_ack || mem_ack || ram_req) quiet = 1'b0;
    end
    n_vec++;
    if (!quiet) begin
      n_err++;
      $display("[TB] FAIL midrst_quiet got activity after abandoned transaction want none");
    end
  endtask

  initial begin
    n_vec = 0; n_err = 0;
    rst = 1'b1; if_req = 1'b0; if_addr = '0;
    mem_req = 1'b0; mem_we = 1'b0; mem_be = '0; mem_addr = '0; mem_wdata = '0;
    ram_wait = 0; stray_ack = 1'b0; rd_override_en = 1'b0; rd_override = '0;
    last_if_rdata = '0; last_mem_rdata = '0;

    test_reset();
    test_if_fetch();
    test_mem_load();
    test_mem_store();
    test_streak();
    test_simultaneous();
    test_stray_ack();
    test_reset_mid();

    repeat (2) @(negedge clk);
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++;
      $display("[TB] FAIL sb_leftover got %0d pending acks want 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Watchdog so a stuck handshake can never hang the run.
  initial begin
    #100000;
    $display("[TB] FAIL watchdog got timeout want completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
